// File: rtl/maze_wall_solver_if.sv
// Bus bundle between a maze source/controller and the wall-following solver.
// The master side issues the walk request and maze bitmap; the slave side
// (the solver) reports position, heading, step count and walk status.
interface maze_wall_solver_if;
    logic         start;
    logic [255:0] maze_data;
    logic [3:0]   start_x;
    logic [3:0]   start_y;
    logic [1:0]   start_heading;
    logic [3:0]   goal_x;
    logic [3:0]   goal_y;
    logic [3:0]   curr_x;
    logic [3:0]   curr_y;
    logic [1:0]   heading;
    logic [9:0]   step_count;
    logic         step_valid;
    logic         busy;
    logic         found;
    logic         fail;

    modport master (
        output start, maze_data, start_x, start_y, start_heading, goal_x, goal_y,
        input  curr_x, curr_y, heading, step_count, step_valid, busy, found, fail
    );

    modport slave (
        input  start, maze_data, start_x, start_y, start_heading, goal_x, goal_y,
        output curr_x, curr_y, heading, step_count, step_valid, busy, found, fail
    );
endinterface

// File: rtl/maze_wall_solver.sv
// Right-hand wall follower over a 16x16 maze bitmap.
// Bit x+16*y of maze_data is 1 for an open cell. Each WALK cycle either
// finishes (goal reached / step limit / boxed in) or moves one cell, trying
// right, forward, left and back in that order. Headings: 0=up(y-1),
// 1=left(x-1), 2=down(y+1), 3=right(x+1); a right turn is heading-1.
module maze_wall_solver #(
    parameter int MAX_STEPS = 1023
) (
    input logic          clk,
    input logic          reset,
    maze_wall_solver_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [9:0] STEP_LIMIT = 10'(MAX_STEPS);

    state_t     state;
    state_t     state_next;
    logic [3:0] cx;
    logic [3:0] cx_next;
    logic [3:0] cy;
    logic [3:0] cy_next;
    logic [3:0] gx;
    logic [3:0] gx_next;
    logic [3:0] gy;
    logic [3:0] gy_next;
    logic [1:0] hd;
    logic [1:0] hd_next;
    logic [9:0] cnt;
    logic [9:0] cnt_next;
    logic       moved;
    logic       sv;
    logic [1:0] try_dir;

    // Column of the neighbour in direction dir (only meaningful when on-grid).
    function automatic logic [3:0] step_x(input logic [3:0] x, input logic [1:0] dir);
        logic [3:0] nx;
        nx = x;
        if (dir == 2'd1) nx = x - 4'd1;
        else if (dir == 2'd3) nx = x + 4'd1;
        return nx;
    endfunction

    // Row of the neighbour in direction dir (only meaningful when on-grid).
    function automatic logic [3:0] step_y(input logic [3:0] y, input logic [1:0] dir);
        logic [3:0] ny;
        ny = y;
        if (dir == 2'd0) ny = y - 4'd1;
        else if (dir == 2'd2) ny = y + 4'd1;
        return ny;
    endfunction

    // A neighbour is open only if it stays on the grid (no wrap) and its bit is 1.
    function automatic logic dir_open(input logic [255:0] maze, input logic [3:0] x,
                                      input logic [3:0] y, input logic [1:0] dir);
        logic on_grid;
        case (dir)
            2'd0:    on_grid = (y != 4'd0);
            2'd1:    on_grid = (x != 4'd0);
            2'd2:    on_grid = (y != 4'd15);
            default: on_grid = (x != 4'd15);
        endcase
        return on_grid && maze[{step_y(y, dir), step_x(x, dir)}];
    endfunction

    // Next-state and datapath decision: start handling outside WALK, one
    // goal/limit/move decision per cycle inside WALK.
    always_comb begin
        state_next = state;
        cx_next    = cx;
        cy_next    = cy;
        gx_next    = gx;
        gy_next    = gy;
        hd_next    = hd;
        cnt_next   = cnt;
        moved      = 1'b0;
        try_dir    = 2'd0;
        case (state)
            S_WALK: begin
                if (cx == gx && cy == gy) begin
                    state_next = S_DONE;
                end else if (cnt == STEP_LIMIT) begin
                    state_next = S_FAIL;
                end else begin
                    state_next = S_FAIL;
                    for (int i = 0; i < 4; i++) begin
                        // offsets 3,0,1,2 give right, forward, left, back
                        try_dir = hd + 2'(i + 3);
                        if (!moved && dir_open(bus.maze_data, cx, cy, try_dir)) begin
                            moved      = 1'b1;
                            hd_next    = try_dir;
                            cx_next    = step_x(cx, try_dir);
                            cy_next    = step_y(cy, try_dir);
                            cnt_next   = cnt + 10'd1;
                            state_next = S_WALK;
                        end
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    gx_next    = bus.goal_x;
                    gy_next    = bus.goal_y;
                    cx_next    = bus.start_x;
                    cy_next    = bus.start_y;
                    hd_next    = bus.start_heading;
                    cnt_next   = 10'd0;
                    state_next = bus.maze_data[{bus.start_y, bus.start_x}] ? S_WALK : S_FAIL;
                end
            end
        endcase
    end

    // State and walk registers; reset wins in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cx    <= 4'd0;
            cy    <= 4'd0;
            gx    <= 4'd0;
            gy    <= 4'd0;
            hd    <= 2'b11;
            cnt   <= 10'd0;
            sv    <= 1'b0;
        end else begin
            state <= state_next;
            cx    <= cx_next;
            cy    <= cy_next;
            gx    <= gx_next;
            gy    <= gy_next;
            hd    <= hd_next;
            cnt   <= cnt_next;
            sv    <= moved;
        end
    end

    assign bus.curr_x     = cx;
    assign bus.curr_y     = cy;
    assign bus.heading    = hd;
    assign bus.step_count = cnt;
    assign bus.step_valid = sv;
    assign bus.busy       = (state == S_WALK);
    assign bus.found      = (state == S_DONE);
    assign bus.fail       = (state == S_FAIL);

endmodule
